ad_capture_seq: RTL
===================

Name: ad_capture_seq

Overview:
- Acquisition sequencer in the clk_ad_180M domain, placed between the 8-bit ADC input and the AD-to-system FIFO write port.
- Arms on run, selects the internal or external trigger, and waits a programmable delay after the trigger.
- Then captures a fixed number of decimated samples, packs them two per 16-bit word and writes them to the FIFO.
- Reports done and overflow status to command processing.

Parameters:
- DELAY_W, 16, width of the post-trigger delay counter.
- CNT_W, 16, width of the word-count register (matches the wave raw size field).

Ports:
- clk_ad_180M  in  1  ADC sample clock
- i_rst_n  in  1  async reset, active-low
- i_run  in  1  acquisition enable, level (from 100M domain, synchronised inside)
- i_outmode  in  1  0 = internal trigger, 1 = external trigger
- i_outnegedge  in  1  external trigger polarity: 1 = falling edge
- i_trig_int  in  1  internal trigger pulse/level (100M domain)
- i_trig_ext  in  1  external trigger pin (async)
- i_ad_data  in  8  ADC sample
- i_recv_count  in  CNT_W  16-bit words per shot
- i_rate  in  3  decimation exponent; keep 1 of 2^rate samples
- i_delay  in  DELAY_W  post-trigger delay in clk cycles
- i_fifo_full  in  1  FIFO full (write-domain flag)
- o_fifo_wr  out  1  FIFO write strobe
- o_fifo_data  out  16  packed word: first sample [7:0], second sample [15:8]
- o_busy  out  1  high in DELAY/CAPTURE
- o_done  out  1  one-cycle pulse at end of shot
- o_overflow  out  1  sticky; cleared on next arm

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- i_run, i_trig_int and i_trig_ext each pass through a 2-flop synchroniser.
- Trigger source:
  - i_outmode=0: selected source is synced i_trig_int.
  - i_outmode=1: selected source is synced i_trig_ext, inverted when i_outnegedge=1.
  - A trigger event is the rising edge of the selected source, detected by a third register.
  - Event is seen 3 clk edges after the raw input rises.
- Sample path: ad_q <= i_ad_data every clk (1-cycle pipeline).
- States:
  - IDLE:
    - Go to ARMED when synced run=1.
    - On entry to ARMED, latch i_recv_count, i_rate, i_delay, i_outmode and i_outnegedge, and clear o_overflow.
  - ARMED:
    - On trigger event: go to DELAY if latched delay>0, else CAPTURE.
    - Latched count=0: the trigger produces an o_done pulse with no writes.
  - DELAY: count latched delay cycles, then go to CAPTURE. A trigger at DELAY+0 puts the first CAPTURE cycle at DELAY+delay.
  - CAPTURE:
    - Decimation counter runs 0..(2^rate)-1 and wraps; a sample is taken when it is 0.
    - The first CAPTURE cycle always takes a sample.
    - Taken samples alternate low byte / high byte.
    - On the high byte: o_fifo_data <= {ad_q, low}, o_fifo_wr=1 for exactly one cycle (registered, the cycle after the second sample), word counter +1.
    - When word counter reaches the latched count, go to DONE.
  - DONE: o_done=1 for one cycle, then go to ARMED (relatching config) if run=1, else IDLE.
- FIFO full:
  - If i_fifo_full=1 on the cycle a word would be written: no write, o_overflow<=1, abort to DONE.
  - o_done still pulses.
- Trigger events in DELAY, CAPTURE or DONE are ignored (no retrigger, no queueing).
- run deasserted (synced) in any state:
  - Go to IDLE next cycle; pending half-word discarded; no o_done.
  - o_fifo_wr never asserts after this transition.
  - o_overflow holds its value.
- Config inputs are quasi-static and are sampled only at arm; changes during a shot have no effect.
- Async reset mid-shot: immediately to IDLE with all outputs 0.

Optional Feature:
- Macro AD_TEST_PATTERN_EN.
- When defined:
  - ad_q is replaced by an internal ramp: 0..99, wrapping to 0.
  - The ramp is forced to 248 on the cycle the trigger event is detected, then continues 249..255,0..99 with wrap at 99.
  - i_ad_data is ignored.
- When undefined: ad_q = registered i_ad_data, and no ramp logic is present.

Test Plan:
- Internal trigger, rate=0, delay=0, count=4, ADC ramp 0,1,2,… → exactly 4 writes, words with low byte n and high byte n+1 increasing by 2; o_done one cycle after last write; o_busy high throughout the shot.
- rate=2, delay=10, count=3 → first sample taken 10 cycles after the trigger event, then every 4th sample; 3 writes; high byte = low byte+4.
- External trigger, outnegedge=1: a rising edge → no capture; a falling edge → capture starts; a second falling edge during CAPTURE is ignored.
- i_fifo_full asserted before the 2nd word, count=8 → 1 write, o_overflow=1, o_done pulse; overflow clears on re-arm.
- run dropped during word 2 of count=16 → state IDLE, no further writes, no o_done; re-raise run plus trigger → full 16-word shot.
- count=0 with trigger → o_done pulse, zero writes; with AD_TEST_PATTERN_EN defined, first word of a shot = {249,248}.

Source files
------------

// File: rtl/ad_capture_seq.sv
// ADC capture sequencer: arm on run, trigger, post-trigger delay, decimated capture packed two samples per FIFO word.
// Optional build macro AD_TEST_PATTERN_EN replaces the ADC sample with an internal ramp.
module ad_capture_seq #(
    parameter int DELAY_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk_ad_180M,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_outmode,
    input  logic               i_outnegedge,
    input  logic               i_trig_int,
    input  logic               i_trig_ext,
    input  logic [7:0]         i_ad_data,
    input  logic [CNT_W-1:0]   i_recv_count,
    input  logic [2:0]         i_rate,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic               i_fifo_full,
    output logic               o_fifo_wr,
    output logic [15:0]        o_fifo_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow
);

    // state     | meaning
    // S_IDLE    | run low, waiting to arm
    // S_ARMED   | config latched, waiting for trigger event
    // S_DELAY   | counting post-trigger delay
    // S_CAPTURE | taking decimated samples, writing packed words
    // S_DONE    | shot finished, o_done pulses next cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic run_s1_q, run_s2_q;
    logic tint_s1_q, tint_s2_q;
    logic text_s1_q, text_s2_q;
    logic trig_prev_q, trig_prev_d;

    logic [7:0] ad_q, ad_d;

    logic [CNT_W-1:0]   cnt_lat_q, cnt_lat_d;
    logic [2:0]         rate_lat_q, rate_lat_d;
    logic [DELAY_W-1:0] delay_lat_q, delay_lat_d;
    logic               mode_lat_q, mode_lat_d;
    logic               neg_lat_q, neg_lat_d;

    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [6:0]         dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               hi_q, hi_d;
    logic [7:0]         low_q, low_d;

    logic        wr_q, wr_d;
    logic [15:0] data_q, data_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic             mode_eff, neg_eff;
    logic             trig_sel, trig_evt;
    logic             arm;
    logic [6:0]       dec_mask;
    logic [CNT_W-1:0] word_nxt;

    // Synchronisers for the run level and both trigger sources.
    always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
            tint_s1_q <= 1'b0;
            tint_s2_q <= 1'b0;
            text_s1_q <= 1'b0;
            text_s2_q <= 1'b0;
        end else begin
            run_s1_q  <= i_run;
            run_s2_q  <= run_s1_q;
            tint_s1_q <= i_trig_int;
            tint_s2_q <= tint_s1_q;
            text_s1_q <= i_trig_ext;
            text_s2_q <= text_s1_q;
        end
    end

    // Outside a shot the edge detector follows the live source selection, so
    // latching a new source at arm time cannot fake an edge.
    always_comb begin
        if (state_q == S_IDLE || state_q == S_DONE) begin
            mode_eff = i_outmode;
            neg_eff  = i_outnegedge;
        end else begin
            mode_eff = mode_lat_q;
            neg_eff  = neg_lat_q;
        end
        trig_sel    = mode_eff ? (text_s2_q ^ neg_eff) : tint_s2_q;
        trig_evt    = trig_sel & ~trig_prev_q;
        trig_prev_d = trig_sel;
    end

`ifdef AD_TEST_PATTERN_EN
    logic unused_ad_data;
    assign unused_ad_data = ^i_ad_data;

    always_comb begin
        if (state_q == S_ARMED && trig_evt) begin
            ad_d = 8'd248;
        end else if (ad_q == 8'd99) begin
            ad_d = 8'd0;
        end else begin
            ad_d = ad_q + 8'd1;
        end
    end
`else
    always_comb begin
        ad_d = i_ad_data;
    end
`endif

    assign dec_mask = 7'((8'd1 << rate_lat_q) - 8'd1);
    assign word_nxt = word_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_lat_d   = cnt_lat_q;
        rate_lat_d  = rate_lat_q;
        delay_lat_d = delay_lat_q;
        mode_lat_d  = mode_lat_q;
        neg_lat_d   = neg_lat_q;
        delay_cnt_d = delay_cnt_q;
        dec_cnt_d   = dec_cnt_q;
        word_cnt_d  = word_cnt_q;
        hi_d        = hi_q;
        low_d       = low_q;
        wr_d        = 1'b0;
        data_d      = data_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        arm         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_s2_q) begin
                    state_d = S_ARMED;
                    arm     = 1'b1;
                end
            end
            S_ARMED: begin
                if (trig_evt) begin
                    dec_cnt_d  = '0;
                    hi_d       = 1'b0;
                    word_cnt_d = '0;
                    if (cnt_lat_q == '0) begin
                        state_d = S_DONE;
                    end else if (delay_lat_q != '0) begin
                        state_d     = S_DELAY;
                        delay_cnt_d = delay_lat_q;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_DELAY: begin
                delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                if (delay_cnt_q == DELAY_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                dec_cnt_d = (dec_cnt_q == dec_mask) ? 7'd0 : dec_cnt_q + 7'd1;
                if (dec_cnt_q == 7'd0) begin
                    if (!hi_q) begin
                        low_d = ad_q;
                        hi_d  = 1'b1;
                    end else begin
                        hi_d = 1'b0;
                        if (i_fifo_full) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            wr_d       = 1'b1;
                            data_d     = {ad_q, low_q};
                            word_cnt_d = word_nxt;
                            if (word_nxt == cnt_lat_q) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (run_s2_q) begin
                    state_d = S_ARMED;
                    arm     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (arm) begin
            cnt_lat_d   = i_recv_count;
            rate_lat_d  = i_rate;
            delay_lat_d = i_delay;
            mode_lat_d  = i_outmode;
            neg_lat_d   = i_outnegedge;
            ovf_d       = 1'b0;
        end

        // Dropping run abandons the shot silently: no write, no done, overflow untouched.
        if (!run_s2_q && state_q != S_IDLE) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            data_d  = data_q;
            done_d  = 1'b0;
            ovf_d   = ovf_q;
            hi_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            trig_prev_q <= 1'b0;
            ad_q        <= '0;
            cnt_lat_q   <= '0;
            rate_lat_q  <= '0;
            delay_lat_q <= '0;
            mode_lat_q  <= 1'b0;
            neg_lat_q   <= 1'b0;
            delay_cnt_q <= '0;
            dec_cnt_q   <= '0;
            word_cnt_q  <= '0;
            hi_q        <= 1'b0;
            low_q       <= '0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig_prev_d;
            ad_q        <= ad_d;
            cnt_lat_q   <= cnt_lat_d;
            rate_lat_q  <= rate_lat_d;
            delay_lat_q <= delay_lat_d;
            mode_lat_q  <= mode_lat_d;
            neg_lat_q   <= neg_lat_d;
            delay_cnt_q <= delay_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            word_cnt_q  <= word_cnt_d;
            hi_q        <= hi_d;
            low_q       <= low_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_fifo_wr   = wr_q;
    assign o_fifo_data = data_q;
    assign o_busy      = (state_q == S_DELAY) || (state_q == S_CAPTURE);
    assign o_done      = done_q;
    assign o_overflow  = ovf_q;

endmodule
